// File: rtl/nmr_seq_pkg.sv
// Shared types and constants for the NMR delay/acquisition sequencer.
package nmr_seq_pkg;

  localparam int CNT_W_DEF         = 32;
  localparam int REP_W_DEF         = 16;
  // Power-on value the control PIO presents on delay_nosig.
  localparam int PIO_DELAY_DEFAULT = 16;

  // state | meaning
  // IDLE  | waiting for start
  // DELAY | no-signal delay, acq_en low
  // ACQ   | acquisition window, acq_en high
  // DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    ACQ   = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/nmr_seq_downcounter.sv
// Loadable down-counter shared by the DELAY and ACQ phases.
// Holds at zero instead of wrapping, so the zero flag stays asserted.
module nmr_seq_downcounter
  import nmr_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] r_count;

  // Load has priority over counting; counting stops at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_count <= '0;
    else if (load)
      r_count <= load_val;
    else if (en && (r_count != '0))
      r_count <= r_count - CNT_W'(1);
  end

  assign zero = (r_count == '0);

endmodule

// File: rtl/nmr_delay_sequencer.sv
// NMR acquisition timing controller: N repetitions of (no-signal delay,
// acquisition window) per start. All outputs are registered.
// Optional build macro NMR_SEQ_ABORT_EN adds the abort/aborted ports.
//
// state | meaning
// IDLE  | waiting for start
// DELAY | acq_en=0 for D cycles
// ACQ   | acq_en=1 for A cycles
// DONE  | done=1 for one cycle, then IDLE
module nmr_delay_sequencer
  import nmr_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int REP_W = REP_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] delay_nosig,
  input  logic [CNT_W-1:0] acq_len,
  input  logic [REP_W-1:0] num_rep,
`ifdef NMR_SEQ_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic             busy,
  output logic             acq_en,
  output logic [REP_W-1:0] rep_idx,
  output logic             done,
  output logic             err_param
);

  seq_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_d, r_a;
  logic [REP_W-1:0] r_n;
  logic [REP_W-1:0] r_rep_idx, w_rep_nxt, w_rep_inc;
  logic             r_busy, r_acq_en, r_done, r_err;
  logic             w_err_nxt, w_accept, w_abort_nxt;
  logic             w_cnt_load, w_cnt_en, w_cnt_zero;
  logic [CNT_W-1:0] w_cnt_load_val;

  nmr_seq_downcounter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (w_cnt_load),
    .load_val (w_cnt_load_val),
    .en       (w_cnt_en),
    .zero     (w_cnt_zero)
  );

  // rep_idx < N <= 2^REP_W-1, so the increment cannot wrap.
  assign w_rep_inc = r_rep_idx + REP_W'(1);
  assign w_cnt_en  = (r_state == DELAY) || (r_state == ACQ);

  // Next-state, counter reload and pulse decisions.
  always_comb begin
    w_state_nxt    = r_state;
    w_rep_nxt      = r_rep_idx;
    w_cnt_load     = 1'b0;
    w_cnt_load_val = '0;
    w_err_nxt      = 1'b0;
    w_accept       = 1'b0;
    w_abort_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if ((acq_len == '0) || (num_rep == '0)) begin
            w_err_nxt = 1'b1;
          end else begin
            w_accept   = 1'b1;
            w_rep_nxt  = '0;
            w_cnt_load = 1'b1;
            if (delay_nosig != '0) begin
              w_state_nxt    = DELAY;
              w_cnt_load_val = delay_nosig - CNT_W'(1);
            end else begin
              w_state_nxt    = ACQ;
              w_cnt_load_val = acq_len - CNT_W'(1);
            end
          end
        end
      end
      DELAY: begin
        if (w_cnt_zero) begin
          w_state_nxt    = ACQ;
          w_cnt_load     = 1'b1;
          w_cnt_load_val = r_a - CNT_W'(1);
        end
      end
      ACQ: begin
        if (w_cnt_zero) begin
          if (w_rep_inc < r_n) begin
            w_rep_nxt  = w_rep_inc;
            w_cnt_load = 1'b1;
            if (r_d != '0) begin
              w_state_nxt    = DELAY;
              w_cnt_load_val = r_d - CNT_W'(1);
            end else begin
              w_state_nxt    = ACQ;
              w_cnt_load_val = r_a - CNT_W'(1);
            end
          end else begin
            w_state_nxt = DONE;
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_rep_nxt   = '0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_rep_nxt   = '0;
      end
    endcase
`ifdef NMR_SEQ_ABORT_EN
    // Abort overrides everything, including the final ACQ->DONE step.
    if (abort && (r_state != IDLE)) begin
      w_state_nxt = IDLE;
      w_rep_nxt   = '0;
      w_cnt_load  = 1'b0;
      w_abort_nxt = 1'b1;
    end
`endif
  end

  // State, snapshot and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_d       <= '0;
      r_a       <= '0;
      r_n       <= '0;
      r_rep_idx <= '0;
      r_busy    <= 1'b0;
      r_acq_en  <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rep_idx <= w_rep_nxt;
      r_busy    <= (w_state_nxt != IDLE);
      r_acq_en  <= (w_state_nxt == ACQ);
      r_done    <= (w_state_nxt == DONE);
      r_err     <= w_err_nxt;
      if (w_accept) begin
        r_d <= delay_nosig;
        r_a <= acq_len;
        r_n <= num_rep;
      end
    end
  end

`ifdef NMR_SEQ_ABORT_EN
  logic r_aborted;

  // One-cycle abort acknowledge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_aborted <= 1'b0;
    else
      r_aborted <= w_abort_nxt;
  end

  assign aborted = r_aborted;
`else
  logic w_abort_unused;
  assign w_abort_unused = w_abort_nxt;
`endif

  assign busy      = r_busy;
  assign acq_en    = r_acq_en;
  assign rep_idx   = r_rep_idx;
  assign done      = r_done;
  assign err_param = r_err;

endmodule

// File: tb/tb_nmr_delay_sequencer.sv
// Scoreboard bench for nmr_delay_sequencer. Expected per-cycle outputs are
// derived from D/A/N arithmetic and queued at stimulus time; a negedge
// monitor pops and compares. Abort scenarios need NMR_SEQ_ABORT_EN.
module tb_nmr_delay_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] delay_nosig;
  logic [31:0] acq_len;
  logic [15:0] num_rep;
  logic        abort;
  logic        aborted;
  logic        busy, acq_en, done, err_param;
  logic [15:0] rep_idx;

  int     errors = 0;
  int     checks = 0;
  int     cyc    = 0;
  longint seq_end = -1;

  localparam longint MAXPUSH = 5000;

  typedef struct {
    longint      cyc;
    logic        busy;
    logic        acq;
    logic [15:0] rep;
    logic        dn;
    logic        er;
    logic        ab;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  nmr_delay_sequencer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .delay_nosig (delay_nosig),
    .acq_len     (acq_len),
    .num_rep     (num_rep),
`ifdef NMR_SEQ_ABORT_EN
    .abort       (abort),
    .aborted     (aborted),
`endif
    .busy        (busy),
    .acq_en      (acq_en),
    .rep_idx     (rep_idx),
    .done        (done),
    .err_param   (err_param)
  );

`ifndef NMR_SEQ_ABORT_EN
  assign aborted = 1'b0;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push_rec(longint cy, logic b, logic acq, logic [15:0] rep,
                                   logic dn, logic er, logic ab);
    exp_t r;
    r.cyc = cy; r.busy = b; r.acq = acq; r.rep = rep; r.dn = dn; r.er = er; r.ab = ab;
    exp_q.push_back(r);
  endfunction

  function automatic void flush_from(longint k);
    while (exp_q.size() > 0 && exp_q[$].cyc >= k) void'(exp_q.pop_back());
  endfunction

  // Monitor: compare DUT outputs against the queued expectation for this cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < longint'(cyc)) begin
      checks++; errors++;
      $display("FAIL missed_check cyc=%0d", exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == longint'(cyc)) begin
      e = exp_q.pop_front();
      checks++;
      if ({busy, acq_en, rep_idx, done, err_param, aborted} !==
          {e.busy, e.acq, e.rep, e.dn, e.er, e.ab}) begin
        errors++;
        $display("FAIL outputs cyc=%0d got busy=%b acq_en=%b rep=%0d done=%b err=%b abt=%b want busy=%b acq_en=%b rep=%0d done=%b err=%b abt=%b",
                 cyc, busy, acq_en, rep_idx, done, err_param, aborted,
                 e.busy, e.acq, e.rep, e.dn, e.er, e.ab);
      end
    end
  end

  // One stimulus cycle; the reference model queues what the DUT must show.
  task automatic step(input logic st, input logic [31:0] d, input logic [31:0] a,
                      input logic [15:0] n, input logic ab);
    longint c, len, per;
    @(posedge clk); #1;
    c = longint'(cyc);
    start = st; delay_nosig = d; acq_len = a; num_rep = n; abort = ab;
`ifdef NMR_SEQ_ABORT_EN
    if (ab && c <= seq_end) begin
      flush_from(c + 1);
      push_rec(c + 1, 0, 0, 16'd0, 0, 0, 1);
      seq_end = c;
      return;
    end
`endif
    if (c > seq_end) begin
      if (st && (a == 0 || n == 0)) begin
        push_rec(c + 1, 0, 0, 16'd0, 0, 1, 0);
      end else if (st) begin
        per = longint'(d) + longint'(a);
        len = longint'(n) * per + 1;
        for (longint k = 1; k < len && k <= MAXPUSH; k++)
          push_rec(c + k, 1, ((k - 1) % per) >= longint'(d), 16'((k - 1) / per), 0, 0, 0);
        if (len <= MAXPUSH) push_rec(c + len, 1, 0, n - 16'd1, 1, 0, 0);
        seq_end = c + len;
      end else begin
        push_rec(c + 1, 0, 0, 16'd0, 0, 0, 0);
      end
    end else if (c == seq_end) begin
      push_rec(c + 1, 0, 0, 16'd0, 0, 0, 0);
    end
  endtask

  task automatic tick();
    step(1'b0, delay_nosig, acq_len, num_rep, 1'b0);
  endtask

  task automatic run_until_idle();
    while (longint'(cyc) < seq_end) tick();
    tick();
  endtask

  // Assert reset now and check the asynchronous drop of every output.
  task automatic assert_reset_now();
    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    flush_from(longint'(cyc));
    #1;
    checks++;
    if ({busy, acq_en, rep_idx, done, err_param, aborted} !== 21'd0) begin
      errors++;
      $display("FAIL async_reset got busy=%b acq_en=%b rep=%0d done=%b err=%b abt=%b want all 0",
               busy, acq_en, rep_idx, done, err_param, aborted);
    end
  endtask

  task automatic hold_and_release(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      push_rec(longint'(cyc) + 1, 0, 0, 16'd0, 0, 0, 0);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    push_rec(longint'(cyc) + 1, 0, 0, 16'd0, 0, 0, 0);
    seq_end = -1;
  endtask

  task automatic reset_mid_cycle();
    @(posedge clk); #3;
    assert_reset_now();
    hold_and_release(3);
  endtask

  initial begin
    int r;
    reset_n = 1'b1; start = 1'b0; abort = 1'b0;
    delay_nosig = 32'd16; acq_len = 32'd4; num_rep = 16'd1;
    #2;
    assert_reset_now();
    hold_and_release(3);
    tick(); tick();

    // PIO default delay
    step(1, 32'd16, 32'd4, 16'd1, 0);
    run_until_idle();
    // multi-repetition
    step(1, 32'd3, 32'd2, 16'd3, 0);
    run_until_idle();
    // zero delay, back-to-back windows
    step(1, 32'd0, 32'd5, 16'd2, 0);
    run_until_idle();
    // snapshot + ignored restart on cycle 5
    step(1, 32'd16, 32'd4, 16'd1, 0);
    repeat (4) tick();
    step(1, 32'd100, 32'd4, 16'd1, 0);
    run_until_idle();
    // start exactly on the DONE cycle is ignored
    step(1, 32'd1, 32'd1, 16'd1, 0);
    tick(); tick();
    step(1, 32'd2, 32'd2, 16'd1, 0);
    tick();
    // rejected starts
    step(1, 32'd5, 32'd3, 16'd0, 0);
    tick();
    step(1, 32'd5, 32'd0, 16'd2, 0);
    tick();
    // reset during ACQ
    step(1, 32'd2, 32'd6, 16'd1, 0);
    repeat (4) tick();
    reset_mid_cycle();
    tick();
    // maximum delay must not wrap
    step(1, 32'hFFFF_FFFF, 32'd3, 16'd2, 0);
    repeat (300) tick();
    reset_mid_cycle();
    tick();

`ifdef NMR_SEQ_ABORT_EN
    // abort in DELAY of rep 1 (cycles 6..8)
    step(1, 32'd3, 32'd2, 16'd3, 0);
    repeat (5) tick();
    step(0, 32'd3, 32'd2, 16'd3, 1);
    repeat (3) tick();
    // abort coinciding with final ACQ->DONE
    step(1, 32'd1, 32'd1, 16'd1, 0);
    step(0, 32'd1, 32'd1, 16'd1, 0);
    step(0, 32'd1, 32'd1, 16'd1, 1);
    tick(); tick();
    // abort in IDLE is ignored
    step(0, 32'd1, 32'd1, 16'd1, 1);
    tick();
`endif

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if (longint'(cyc) + 1 > seq_end) begin
        if ($urandom_range(0, 2) == 0)
          step(1, $urandom_range(0, 5), $urandom_range(0, 4), 16'($urandom_range(0, 3)), 0);
        else
          tick();
      end else begin
        r = int'($urandom_range(0, 39));
        if (r < 4)
          step(1, $urandom_range(0, 40), $urandom_range(0, 40), 16'($urandom_range(0, 5)), 0);
        else if (r < 8)
          step(0, $urandom_range(0, 40), $urandom_range(0, 40), 16'($urandom_range(0, 5)), 0);
`ifdef NMR_SEQ_ABORT_EN
        else if (r == 8)
          step(0, delay_nosig, acq_len, num_rep, 1);
`endif
        else
          tick();
      end
    end

    run_until_idle();
    repeat (3) tick();
    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nmr_delay_sequencer.md
Name: nmr_delay_sequencer

Overview:
Timing controller for one NMR acquisition sequence. It consumes the software-written parameter words: the no-signal delay, the acquisition length and the repetition count. On each start it runs N repetitions of a no-signal delay followed by an acquisition window. It drives the acquisition enable to the ADC capture path and reports busy/done status back to the HPS-visible PIO.

Parameters:
CNT_W, 32, width of the delay and acquisition-length counters (matches 32-bit parameter PIO words)
REP_W, 16, width of the repetition count and index

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  single-cycle start request from the control PIO
delay_nosig  in  CNT_W  delay length in clk cycles before each acquisition window (PIO reset default 16)
acq_len  in  CNT_W  acquisition window length in clk cycles
num_rep  in  REP_W  number of delay+acquisition repetitions
busy  out  1  sequence in progress
acq_en  out  1  acquisition window active
rep_idx  out  REP_W  index of the current repetition, 0-based
done  out  1  one-cycle pulse at normal completion
err_param  out  1  one-cycle pulse when start is rejected

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values: state IDLE; all outputs 0; all counters 0.
- All outputs are registered.
- States:
  - IDLE: waiting for start.
  - DELAY: acq_en=0 for D cycles.
  - ACQ: acq_en=1 for A cycles.
  - DONE: done=1 for one cycle, then return to IDLE.
- Parameter snapshot: D, A and N are captured from delay_nosig, acq_len and num_rep on the accepted start cycle. Later input changes have no effect until the next start.
- Rejected start: start in IDLE with acq_len==0 or num_rep==0 gives err_param=1 on the next cycle, and the block stays in IDLE.
- Accepted start (call the start cycle cycle 0):
  - Cycle 1: busy=1, rep_idx=0.
  - The state on cycle 1 is DELAY if D>0, otherwise ACQ.
  - DELAY holds exactly D cycles.
  - ACQ holds exactly A cycles.
- End of an ACQ window:
  - If rep_idx+1<N: increment rep_idx and enter DELAY (or ACQ if D==0). Do not insert a gap cycle.
  - Otherwise: enter DONE.
- Timing:
  - First acq_en=1 is on cycle 1+D.
  - DONE (done=1, busy=1) is on cycle N*(D+A)+1.
  - busy=0 and rep_idx=0 on the following cycle.
- Start while busy is ignored, including during DONE.
- Counters are down-counters loaded with value−1, and the state exits when the count reaches 0. D=2^32−1 is legal and must not wrap.
- Reset asserted mid-sequence: all outputs drop immediately (asynchronously) to reset values; done is not pulsed.

Optional Feature:
- Macro name: NMR_SEQ_ABORT_EN.
- Defined:
  - Adds port abort (in, 1) and port aborted (out, 1, pulse).
  - abort=1 in any non-IDLE state gives, on the next cycle: state IDLE, busy=0, acq_en=0, rep_idx=0, aborted=1 for one cycle, done=0.
  - abort in IDLE is ignored.
  - If abort and the final ACQ→DONE transition occur on the same cycle, abort wins.
- Undefined: neither port exists, and a sequence always runs to completion or reset.

Decomposition:
- Package nmr_seq_pkg holds:
  - the state enum {IDLE, DELAY, ACQ, DONE};
  - the CNT_W/REP_W default constants;
  - the localparam for the PIO default delay (16).
- One sub-module is natural: nmr_seq_downcounter.
  - Loadable CNT_W down-counter.
  - Ports: load, load_val, en, zero flag.
  - Instantiated once and shared between the DELAY and ACQ phases.

Test Plan:
- Reset defaults: D=16, A=4, N=1, start at cycle 0 → acq_en high on cycles 17–20; done on cycle 21; busy on cycles 1–21.
- Multi-repetition: D=3, A=2, N=3 → acq_en on cycles 4–5, 9–10 and 14–15; rep_idx 0/1/2; done on cycle 16.
- Zero delay: D=0, A=5, N=2 → acq_en continuously high on cycles 1–10 with rep_idx stepping on cycle 6; done on cycle 11.
- Snapshot and ignored restart: change delay_nosig to 100 and pulse start on cycle 5 of a D=16 run → timing unchanged and no second sequence.
- Rejected start: start with num_rep=0 → err_param on cycle 1, busy stays 0. Repeat with acq_len=0 → same result.
- Reset mid-sequence and abort: deassert reset_n during ACQ → outputs go to 0 asynchronously, no done. With NMR_SEQ_ABORT_EN defined, abort during DELAY of rep 1 → aborted pulse next cycle, no done.
